// File: rtl/ika2151_dac_rx_if.sv
// Sound-link bundle between the OPM serial output and the DAC receiver.
// Inputs (i_*): tick enable, serial data and the two sample-hold strobes.
// Outputs (o_*): per-channel PCM with valid pulses, lock status, exponent error flag.
interface ika2151_dac_rx_if;
  logic        i_phi1_NCEN_n;
  logic        i_SO;
  logic        i_SH1;
  logic        i_SH2;
  logic [15:0] o_CH1;
  logic [15:0] o_CH2;
  logic        o_CH1_VALID;
  logic        o_CH2_VALID;
  logic        o_LOCKED;
  logic        o_EXP_ERR;

  // Driver side (OPM core / testbench)
  modport master (
    output i_phi1_NCEN_n, i_SO, i_SH1, i_SH2,
    input  o_CH1, o_CH2, o_CH1_VALID, o_CH2_VALID, o_LOCKED, o_EXP_ERR
  );

  // Receiver side (DAC front end)
  modport slave (
    input  i_phi1_NCEN_n, i_SO, i_SH1, i_SH2,
    output o_CH1, o_CH2, o_CH1_VALID, o_CH2_VALID, o_LOCKED, o_EXP_ERR
  );
endinterface

// File: rtl/ika2151_dac_rx.sv
// YM3012-style DAC front end: deserialises SO, latches a float word per channel on SHx fall,
// decodes to signed 16-bit PCM and qualifies the samples with a frame-lock state machine.
// Ports: i_EMUCLK clock, i_MRST sync active-high reset, io_dac bundle (see ika2151_dac_rx_if).
module ika2151_dac_rx #(
  parameter int FRAME_LEN = 32,
  parameter int LOCK_CNT  = 2
) (
  input  logic              i_EMUCLK,
  input  logic              i_MRST,
  ika2151_dac_rx_if.slave   io_dac
);

  localparam int         GW         = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [5:0] FRAME_LEN6 = FRAME_LEN[5:0];
  localparam logic [GW-1:0] LOCK_G  = LOCK_CNT[GW-1:0];

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNCING  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_sr;
  logic            r_sh1_z, r_sh2_z;
  logic [5:0]      r_cnt, w_cnt_nxt;
  logic [GW-1:0]   r_good, w_good_nxt, w_good_inc;

  logic            w_tick, w_fall1, w_fall2, w_spacing_ok, w_timeout;
  logic [2:0]      w_exp, w_shamt;
  logic [9:0]      w_man;
  logic [15:0]     w_s16, w_pcm;

  assign w_tick  = ~io_dac.i_phi1_NCEN_n;
  assign w_fall1 = w_tick & r_sh1_z & ~io_dac.i_SH1;
  assign w_fall2 = w_tick & r_sh2_z & ~io_dac.i_SH2;

  // Word is read from the register before this tick's shift: the bit on SO during the
  // fall tick belongs to the next word.
  assign w_exp   = r_sr[15:13];
  assign w_man   = r_sr[12:3];

  // Mantissa sign bit is inverted (1 = positive); exponent 0 decodes like exponent 1.
  assign w_s16   = {{6{~w_man[9]}}, ~w_man[9], w_man[8:0]};
  assign w_shamt = (w_exp == 3'd0) ? 3'd0 : (w_exp - 3'd1);
  assign w_pcm   = w_s16 << w_shamt;

  // Period counter: the fall tick itself is tick 1 of the next interval; saturates at 63.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_fall1)
      w_cnt_nxt = 6'd1;
    else if (r_cnt != 6'd63)
      w_cnt_nxt = r_cnt + 6'd1;
  end

  assign w_spacing_ok = (r_cnt == FRAME_LEN6);
  // Timeout looks at the post-tick count so o_LOCKED drops on the tick the count passes FRAME_LEN.
  assign w_timeout    = ~w_fall1 & (w_cnt_nxt > FRAME_LEN6);
  assign w_good_inc   = r_good + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    if (w_tick) begin
      unique case (r_state)
        ST_UNLOCKED: begin
          if (w_fall1) begin
            w_state_nxt = ST_SYNCING;
            w_good_nxt  = '0;
          end
        end
        ST_SYNCING: begin
          if (w_fall1) begin
            if (w_spacing_ok) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc == LOCK_G)
                w_state_nxt = ST_LOCKED;
            end else begin
              w_good_nxt = '0;
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_fall1 && !w_spacing_ok) begin
            w_state_nxt = ST_SYNCING;
            w_good_nxt  = '0;
          end else if (w_timeout) begin
            w_state_nxt = ST_UNLOCKED;
          end
        end
        default: begin
          w_state_nxt = ST_UNLOCKED;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      r_sr               <= '0;
      r_sh1_z            <= 1'b0;
      r_sh2_z            <= 1'b0;
      r_cnt              <= '0;
      r_good             <= '0;
      r_state            <= ST_UNLOCKED;
      io_dac.o_CH1       <= '0;
      io_dac.o_CH2       <= '0;
      io_dac.o_CH1_VALID <= 1'b0;
      io_dac.o_CH2_VALID <= 1'b0;
      io_dac.o_LOCKED    <= 1'b0;
      io_dac.o_EXP_ERR   <= 1'b0;
    end else begin
      // Valid pulses last one EMUCLK cycle regardless of tick rate.
      io_dac.o_CH1_VALID <= 1'b0;
      io_dac.o_CH2_VALID <= 1'b0;
      if (w_tick) begin
        r_sr            <= (r_sr >> 1) | {io_dac.i_SO, 15'd0};
        r_sh1_z         <= io_dac.i_SH1;
        r_sh2_z         <= io_dac.i_SH2;
        r_cnt           <= w_cnt_nxt;
        r_good          <= w_good_nxt;
        r_state         <= w_state_nxt;
        io_dac.o_LOCKED <= (w_state_nxt == ST_LOCKED);
        if (w_fall1) begin
          io_dac.o_CH1       <= w_pcm;
          io_dac.o_CH1_VALID <= (r_state == ST_LOCKED);
        end
        if (w_fall2) begin
          io_dac.o_CH2       <= w_pcm;
          io_dac.o_CH2_VALID <= (r_state == ST_LOCKED);
        end
        if ((w_fall1 || w_fall2) && (w_exp == 3'd0))
          io_dac.o_EXP_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ika2151_dac_rx.sv
// Directed bench for ika2151_dac_rx: one tick every three EMUCLK cycles, words framed LSB-first
// so the last data bit lands on the tick before the strobe fall.
module tb_ika2151_dac_rx;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  logic v1_tick, v2_tick, v1_idle, v2_idle;

  ika2151_dac_rx_if dac ();

  ika2151_dac_rx #(.FRAME_LEN(32), .LOCK_CNT(2)) dut (
    .i_EMUCLK (clk),
    .i_MRST   (rst),
    .io_dac   (dac.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One enabled tick, followed by a disabled cycle; valids sampled after each.
  task automatic tick(input logic so, input logic sh1, input logic sh2);
    @(negedge clk);
    dac.i_SO = so; dac.i_SH1 = sh1; dac.i_SH2 = sh2; dac.i_phi1_NCEN_n = 1'b0;
    @(negedge clk);
    dac.i_phi1_NCEN_n = 1'b1;
    v1_tick = dac.o_CH1_VALID; v2_tick = dac.o_CH2_VALID;
    @(negedge clk);
    v1_idle = dac.o_CH1_VALID; v2_idle = dac.o_CH2_VALID;
  endtask

  // len ticks; the 13-bit word {e,m} occupies ticks len-14..len-2 and the selected
  // strobes fall on tick len-1.
  task automatic frame(input logic [2:0] e, input logic [9:0] m, input int len,
                       input bit f1, input bit f2);
    logic [12:0] w;
    w = {e, m};
    for (int k = 0; k < len; k++) begin
      logic so;
      if (k >= len - 14 && k <= len - 2) so = w[k - (len - 14)];
      else                               so = 1'($urandom);
      tick(so, !(f1 && k == len - 1), !(f2 && k == len - 1));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ch1"},    dac.o_CH1, 16'h0000);
    chk({tag, ".ch2"},    dac.o_CH2, 16'h0000);
    chk({tag, ".v1"},     16'(dac.o_CH1_VALID), 16'd0);
    chk({tag, ".v2"},     16'(dac.o_CH2_VALID), 16'd0);
    chk({tag, ".locked"}, 16'(dac.o_LOCKED), 16'd0);
    chk({tag, ".experr"}, 16'(dac.o_EXP_ERR), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    dac.i_phi1_NCEN_n = 1'b1; dac.i_SO = 1'b0; dac.i_SH1 = 1'b1; dac.i_SH2 = 1'b1;
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    chk_reset_state("rst0");

    // SH2-only word while unlocked: M=0x1FF E=3 -> -4
    frame(3'd3, 10'h1FF, 32, 0, 1);
    chk("sh2only.ch2",    dac.o_CH2, 16'hFFFC);
    chk("sh2only.v2",     16'(v2_tick), 16'd0);
    chk("sh2only.ch1",    dac.o_CH1, 16'h0000);
    chk("sh2only.locked", 16'(dac.o_LOCKED), 16'd0);

    // Acquire lock: falls 1..3, lock after the third
    frame(3'd7, 10'h3FF, 32, 1, 0);
    chk("acq1.ch1",    dac.o_CH1, 16'h7FC0);
    chk("acq1.v1",     16'(v1_tick), 16'd0);
    chk("acq1.locked", 16'(dac.o_LOCKED), 16'd0);
    frame(3'd1, 10'h200, 32, 1, 0);
    chk("acq2.ch1",    dac.o_CH1, 16'h0000);
    chk("acq2.locked", 16'(dac.o_LOCKED), 16'd0);
    frame(3'd5, 10'h3FF, 32, 1, 0);
    chk("acq3.ch1",    dac.o_CH1, 16'h1FF0);
    chk("acq3.v1",     16'(v1_tick), 16'd0);
    chk("acq3.locked", 16'(dac.o_LOCKED), 16'd1);
    frame(3'd7, 10'h3FF, 32, 1, 0);
    chk("lk.ch1",    dac.o_CH1, 16'h7FC0);
    chk("lk.v1",     16'(v1_tick), 16'd1);
    chk("lk.v1idle", 16'(v1_idle), 16'd0);
    chk("lk.v2",     16'(v2_tick), 16'd0);
    chk("lk.locked", 16'(dac.o_LOCKED), 16'd1);

    // Both strobes on the same tick: M=0 E=7 -> -32768
    frame(3'd7, 10'h000, 32, 1, 1);
    chk("both.ch1",    dac.o_CH1, 16'h8000);
    chk("both.ch2",    dac.o_CH2, 16'h8000);
    chk("both.v1",     16'(v1_tick), 16'd1);
    chk("both.v2",     16'(v2_tick), 16'd1);
    chk("both.v1idle", 16'(v1_idle), 16'd0);
    chk("both.v2idle", 16'(v2_idle), 16'd0);
    chk("both.experr", 16'(dac.o_EXP_ERR), 16'd0);

    // Exponent 0: decodes like E=1 and sets the sticky flag
    frame(3'd0, 10'h201, 32, 1, 0);
    chk("e0.ch1",    dac.o_CH1, 16'h0001);
    chk("e0.experr", 16'(dac.o_EXP_ERR), 16'd1);
    chk("e0.v1",     16'(v1_tick), 16'd1);
    chk("e0.ch2",    dac.o_CH2, 16'h8000);
    frame(3'd3, 10'h1FF, 32, 1, 0);
    chk("e0b.ch1",    dac.o_CH1, 16'hFFFC);
    chk("e0b.experr", 16'(dac.o_EXP_ERR), 16'd1);
    chk("e0b.locked", 16'(dac.o_LOCKED), 16'd1);

    // Short interval (31 ticks) drops to SYNCING; two good intervals relock
    frame(3'd2, 10'h3FF, 31, 1, 0);
    chk("short.ch1",    dac.o_CH1, 16'h03FE);
    chk("short.locked", 16'(dac.o_LOCKED), 16'd0);
    frame(3'd1, 10'h3FF, 32, 1, 0);
    chk("resync1.ch1",    dac.o_CH1, 16'h01FF);
    chk("resync1.v1",     16'(v1_tick), 16'd0);
    chk("resync1.locked", 16'(dac.o_LOCKED), 16'd0);
    frame(3'd4, 10'h000, 32, 1, 0);
    chk("resync2.ch1",    dac.o_CH1, 16'hF000);
    chk("resync2.v1",     16'(v1_tick), 16'd0);
    chk("resync2.locked", 16'(dac.o_LOCKED), 16'd1);
    frame(3'd6, 10'h1FF, 32, 1, 0);
    chk("relock.ch1", dac.o_CH1, 16'hFFE0);
    chk("relock.v1",  16'(v1_tick), 16'd1);

    // SH1 stops: lock holds through count 32, drops when the count reaches 33
    repeat (31) tick(1'($urandom), 1'b1, 1'b1);
    chk("stop31.locked", 16'(dac.o_LOCKED), 16'd1);
    tick(1'b0, 1'b1, 1'b1);
    chk("stop32.locked", 16'(dac.o_LOCKED), 16'd0);

    // Reset mid-word, then lock must be re-acquired from scratch
    for (int k = 0; k < 20; k++) tick(1'($urandom), k < 19, 1'b1);
    rst = 1'b1;
    repeat (3) tick(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    chk_reset_state("rst1");
    frame(3'd7, 10'h3FF, 32, 1, 0);
    chk("rl1.v1",     16'(v1_tick), 16'd0);
    chk("rl1.locked", 16'(dac.o_LOCKED), 16'd0);
    frame(3'd7, 10'h3FF, 32, 1, 0);
    chk("rl2.v1",     16'(v1_tick), 16'd0);
    frame(3'd7, 10'h3FF, 32, 1, 0);
    chk("rl3.v1",     16'(v1_tick), 16'd0);
    chk("rl3.locked", 16'(dac.o_LOCKED), 16'd1);
    frame(3'd7, 10'h3FF, 32, 1, 0);
    chk("rl4.v1",  16'(v1_tick), 16'd1);
    chk("rl4.ch1", dac.o_CH1, 16'h7FC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
